// File: rtl/flash_raid_pkg.sv
// Shared definitions for the flash RAID front end.
//   ctrl_state_e : router FSM encodings (also driven out on ctrl_state)
//   DEC_*        : instruction-decoder phase codes seen on dec_state
//   FLASH_*      : device index used for routing and MISO selection
package flash_raid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BCAST  = 2'd1,
    ST_ROUTED = 2'd2,
    ST_GUARD  = 2'd3
  } ctrl_state_e;

  localparam logic [2:0] DEC_IDLE  = 3'd0;
  localparam logic [2:0] DEC_CMD   = 3'd1;
  localparam logic [2:0] DEC_ADDR  = 3'd2;
  localparam logic [2:0] DEC_DUMMY = 3'd3;
  localparam logic [2:0] DEC_DATA  = 3'd4;

  localparam logic FLASH_MAIN = 1'b0;
  localparam logic FLASH_SEC  = 1'b1;

endpackage

// File: rtl/flash_cs_router_if.sv
// Host/decoder-side inputs and flash-side outputs of flash_cs_router.
//   master : drives h_cs_n, dec_state, dec_flash_select, route_enable, err_clear
//   slave  : the router; drives m_cs_n, s_cs_n, miso_sel, ctrl_state,
//            main_txn_count, sec_txn_count, tcsh_err
interface flash_cs_router_if #(
  parameter int CNT_W = 16
);
  logic             h_cs_n;
  logic [2:0]       dec_state;
  logic             dec_flash_select;
  logic             route_enable;
  logic             err_clear;
  logic             m_cs_n;
  logic             s_cs_n;
  logic             miso_sel;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] main_txn_count;
  logic [CNT_W-1:0] sec_txn_count;
  logic             tcsh_err;

  modport master (
    output h_cs_n, dec_state, dec_flash_select, route_enable, err_clear,
    input  m_cs_n, s_cs_n, miso_sel, ctrl_state, main_txn_count,
           sec_txn_count, tcsh_err
  );

  modport slave (
    input  h_cs_n, dec_state, dec_flash_select, route_enable, err_clear,
    output m_cs_n, s_cs_n, miso_sel, ctrl_state, main_txn_count,
           sec_txn_count, tcsh_err
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
//   clk, rst (sync, active-high), inc : increment enable, count : value
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/flash_cs_router.sv
// Chip-select / MISO router between the host SPI port and two flashes.
// Each transaction opens broadcast to both devices; when the decoder reaches
// its data phase (and routing is enabled) the route locks to one flash and the
// other is deselected. A guard window keeps both CS high after every
// transaction, and per-flash counters tally routed transactions.
//   clk, rst        : system clock, synchronous active-high reset
//   bus (slave)     : host CS, decoder phase/selection, route enable,
//                     error clear in; flash CS, MISO select, FSM state,
//                     transaction counters, tCSH error flag out
module flash_cs_router
  import flash_raid_pkg::*;
#(
  parameter int GUARD_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input logic               clk,
  input logic               rst,
  flash_cs_router_if.slave  bus
);

  localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

  logic        cs_r1, cs_r2;
  logic        cs_act, cs_rise;
  ctrl_state_e state, state_d;
  logic        sel, sel_d;
  logic        m_cs_n, m_cs_n_d;
  logic        s_cs_n, s_cs_n_d;
  logic        miso_sel, miso_sel_d;
  logic [7:0]  guard_cnt, guard_cnt_d;
  logic        guard_done, guard_done_d;
  logic        tcsh_err;
  logic        inc_main, inc_sec;

  // Host CS is asynchronous; two flops, reset to the deasserted level.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_r1 <= 1'b1;
      cs_r2 <= 1'b1;
    end else begin
      cs_r1 <= bus.h_cs_n;
      cs_r2 <= cs_r1;
    end
  end

  assign cs_act  = ~cs_r2;
  // Host CS falling edge, seen one stage ahead of cs_act.
  assign cs_rise = cs_r2 & ~cs_r1;

  // Flash CS values are computed for the next state so the registered outputs
  // change on the same edge as the state transition.
  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d      = state;
    sel_d        = sel;
    miso_sel_d   = miso_sel;
    m_cs_n_d     = 1'b1;
    s_cs_n_d     = 1'b1;
    guard_cnt_d  = guard_cnt;
    guard_done_d = guard_done;
    inc_main     = 1'b0;
    inc_sec      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cs_act) begin
          state_d  = ST_BCAST;
          m_cs_n_d = 1'b0;
          s_cs_n_d = 1'b0;
        end
      end

      ST_BCAST: begin
        if (!cs_act) begin
          state_d      = ST_GUARD;
          guard_cnt_d  = GUARD_LOAD;
          guard_done_d = 1'b0;
        end else if ((bus.dec_state == DEC_DATA) && bus.route_enable) begin
          state_d    = ST_ROUTED;
          sel_d      = bus.dec_flash_select;
          miso_sel_d = bus.dec_flash_select;
          inc_main   = (bus.dec_flash_select == FLASH_MAIN);
          inc_sec    = (bus.dec_flash_select == FLASH_SEC);
          m_cs_n_d   = (bus.dec_flash_select != FLASH_MAIN);
          s_cs_n_d   = (bus.dec_flash_select != FLASH_SEC);
        end else begin
          m_cs_n_d = 1'b0;
          s_cs_n_d = 1'b0;
        end
      end

      ST_ROUTED: begin
        if (!cs_act) begin
          state_d      = ST_GUARD;
          guard_cnt_d  = GUARD_LOAD;
          guard_done_d = 1'b0;
        end else begin
          m_cs_n_d = (sel != FLASH_MAIN);
          s_cs_n_d = (sel != FLASH_SEC);
        end
      end

      ST_GUARD: begin
        // Count GUARD_LOAD..0, then one terminal cycle: together with the
        // deselect edge this holds both CS high for GUARD_CYCLES+1 cycles.
        if (guard_done) begin
          if (cs_act) begin
            state_d  = ST_BCAST;
            m_cs_n_d = 1'b0;
            s_cs_n_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (guard_cnt == 8'd0) begin
          guard_done_d = 1'b1;
        end else begin
          guard_cnt_d = guard_cnt - 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sel        <= FLASH_MAIN;
      m_cs_n     <= 1'b1;
      s_cs_n     <= 1'b1;
      miso_sel   <= FLASH_MAIN;
      guard_cnt  <= 8'd0;
      guard_done <= 1'b0;
    end else begin
      state      <= state_d;
      sel        <= sel_d;
      m_cs_n     <= m_cs_n_d;
      s_cs_n     <= s_cs_n_d;
      miso_sel   <= miso_sel_d;
      guard_cnt  <= guard_cnt_d;
      guard_done <= guard_done_d;
    end
  end

  // Sticky tCSH violation; a new violation beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcsh_err <= 1'b0;
    end else if (cs_rise && (state == ST_GUARD)) begin
      tcsh_err <= 1'b1;
    end else if (bus.err_clear) begin
      tcsh_err <= 1'b0;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_main_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_main),
    .count (bus.main_txn_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_sec_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_sec),
    .count (bus.sec_txn_count)
  );

  assign bus.m_cs_n     = m_cs_n;
  assign bus.s_cs_n     = s_cs_n;
  assign bus.miso_sel   = miso_sel;
  assign bus.ctrl_state = state;
  assign bus.tcsh_err   = tcsh_err;

endmodule
